// File: rtl/cell_editor.sv
// Click-to-toggle cell editor for a cellular-automaton board, plus the
// free-running step-rate generator that paces the game logic.
`timescale 1ns/1ps
module cell_editor #(
  parameter int LOG_BOARD_SIZE = 8,
  parameter int LOG_MAX_SPEED  = 4,
  parameter int LOG_TICK_DIV   = 20,
  parameter int READ_LATENCY   = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        click_in,
  input  logic [LOG_MAX_SPEED-1:0]    speed_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_y_in,
  input  logic                        logic_busy_in,
  output logic                        step_out,
  output logic                        edit_busy_out,
  output logic [2*LOG_BOARD_SIZE-1:0] mem_addr_out,
  output logic                        mem_we_out,
  output logic                        mem_wdata_out,
  input  logic                        mem_rdata_in
);

  localparam int RD_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int CNT_W = LOG_MAX_SPEED + 1;
  localparam logic [RD_W-1:0]  RD_LAST     = RD_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] FULL_PERIOD = CNT_W'(2 ** LOG_MAX_SPEED);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE
  } state_t;

  state_t state, state_next;

  logic                      click_prev;
  logic                      click_edge;
  logic [LOG_BOARD_SIZE-1:0] x_q;
  logic [LOG_BOARD_SIZE-1:0] y_q;
  logic [RD_W-1:0]           rd_cnt;
  logic                      step_prev;

  logic [LOG_TICK_DIV-1:0]   prescaler;
  logic                      base_tick;
  logic [LOG_MAX_SPEED-1:0]  step_cnt;
  logic                      step_pending;
  logic [CNT_W-1:0]          step_period;
  logic [CNT_W-1:0]          step_cnt_inc;
  logic                      period_done;
  logic                      speed_zero;

  assign click_edge   = click_in & ~click_prev;
  assign base_tick    = &prescaler;
  assign speed_zero   = (speed_in == '0);
  assign step_period  = FULL_PERIOD - CNT_W'(speed_in);
  assign step_cnt_inc = CNT_W'(step_cnt) + CNT_W'(1);
  // Comparing with >= lets a shortened period fire at the next tick
  // even when the count already passed it.
  assign period_done  = base_tick && (step_cnt_inc >= step_period);

  // NOTE: every output and next-state variable gets a default before the
  // case statement, so no path through this block can infer a latch.
  always_comb begin
    state_next    = state;
    step_out      = 1'b0;
    edit_busy_out = 1'b0;
    mem_addr_out  = '0;
    mem_we_out    = 1'b0;
    mem_wdata_out = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (click_edge) begin
          state_next = S_WAIT;
        end else if (step_pending && !logic_busy_in && !speed_zero) begin
          step_out = 1'b1;
        end
      end
      S_WAIT: begin
        edit_busy_out = 1'b1;
        // A step issued last cycle may not yet show as logic_busy_in.
        if (!logic_busy_in && !step_prev) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        edit_busy_out = 1'b1;
        mem_addr_out  = {y_q, x_q};
        if (rd_cnt == RD_LAST) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        edit_busy_out = 1'b1;
        mem_addr_out  = {y_q, x_q};
        mem_we_out    = 1'b1;
        mem_wdata_out = ~mem_rdata_in;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs stay quiet for the whole reset cycle, even mid-edit.
    if (rst_in) begin
      state_next    = S_IDLE;
      step_out      = 1'b0;
      edit_busy_out = 1'b0;
      mem_addr_out  = '0;
      mem_we_out    = 1'b0;
      mem_wdata_out = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      click_prev <= click_in;
      x_q        <= '0;
      y_q        <= '0;
      rd_cnt     <= '0;
      step_prev  <= 1'b0;
    end else begin
      state      <= state_next;
      click_prev <= click_in;
      step_prev  <= step_out;
      if (state == S_IDLE && click_edge) begin
        x_q <= cursor_x_in;
        y_q <= cursor_y_in;
      end
      if (state == S_READ) begin
        rd_cnt <= rd_cnt + RD_W'(1);
      end else begin
        rd_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prescaler    <= '0;
      step_cnt     <= '0;
      step_pending <= 1'b0;
    end else begin
      prescaler <= prescaler + LOG_TICK_DIV'(1);
      if (speed_zero) begin
        step_cnt     <= '0;
        step_pending <= 1'b0;
      end else begin
        if (base_tick) begin
          step_cnt <= period_done ? '0 : step_cnt_inc[LOG_MAX_SPEED-1:0];
        end
        // A fresh expiry re-arms even in the cycle a pending step is consumed.
        if (period_done) begin
          step_pending <= 1'b1;
        end else if (step_out) begin
          step_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/cell_editor.md
CELL_EDITOR -- requirements
Module: cell_editor

Interface
REQ-001 Parameter LOG_BOARD_SIZE, default 8, board is 2**LOG_BOARD_SIZE cells per side.
REQ-002 Parameter LOG_MAX_SPEED, default 4, width of speed_in.
REQ-003 Parameter LOG_TICK_DIV, default 20, base-tick prescaler is 2**LOG_TICK_DIV cycles.
REQ-004 Parameter READ_LATENCY, default 2, board memory read latency in cycles, minimum 1.
REQ-005 clk_in  input  1  sole clock; all logic on posedge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 click_in  input  1  debounced click level from the user interface.
REQ-008 speed_in  input  LOG_MAX_SPEED  step rate; 0 = paused.
REQ-009 cursor_x_in, cursor_y_in  input  LOG_BOARD_SIZE each  cursor cell coordinates.
REQ-010 logic_busy_in  input  1  game logic is computing a generation and owns the board memory.
REQ-011 step_out  output  1  one-cycle request to the game logic to compute the next generation.
REQ-012 edit_busy_out  output  1  editor owns the board memory.
REQ-013 mem_addr_out  output  2*LOG_BOARD_SIZE  board address {y, x}.
REQ-014 mem_we_out  output  1  write enable; mem_wdata_out  output  1  cell value written.
REQ-015 mem_rdata_in  input  1  cell value, valid READ_LATENCY cycles after the address is driven.

Function
REQ-016 Click edge: a click is a 0->1 transition of click_in versus its registered previous value.
REQ-017 On a click edge in IDLE, cursor_x_in and cursor_y_in SHALL be latched and the FSM SHALL enter WAIT.
REQ-018 FSM states: IDLE, WAIT, READ, WRITE; edit_busy_out=1 in every state except IDLE.
REQ-019 WAIT->READ when logic_busy_in=0 and step_out was 0 in the previous cycle; otherwise WAIT holds.
REQ-020 READ: mem_addr_out={latched y, latched x}, mem_we_out=0, held exactly READ_LATENCY cycles.
REQ-021 WRITE: exactly one cycle, mem_we_out=1, mem_wdata_out = ~mem_rdata_in sampled on entry to WRITE, same address; then IDLE.
REQ-022 Click-to-write latency with logic idle: write cycle occurs READ_LATENCY+2 cycles after the edge cycle.
REQ-023 Click edges outside IDLE are ignored (not queued); cursor changes after latching have no effect.
REQ-024 mem_we_out=0 in every state except WRITE; mem_addr_out and mem_wdata_out are 0 in IDLE.
REQ-025 Prescaler: free-running LOG_TICK_DIV-bit counter; base tick when it wraps to 0.
REQ-026 Step counter counts base ticks; when it reaches (2**LOG_MAX_SPEED - speed_in) it clears and sets step_pending.
REQ-027 speed_in=0 clears the step counter and step_pending; no step_out is issued.
REQ-028 A speed_in change SHALL take effect at the next base tick; if the counter already exceeds the new period, the step fires at that tick.
REQ-029 step_out=1 for one cycle when step_pending=1, FSM in IDLE, no click edge this cycle, logic_busy_in=0; step_pending clears the same cycle.
REQ-030 At most one step pending; further periods expiring while pending are dropped.
REQ-031 Simultaneous click edge and eligible step: the edit wins, step stays pending until the FSM returns to IDLE.

Reset
REQ-032 During rst_in: FSM=IDLE, step_out=0, edit_busy_out=0, mem_we_out=0, mem_addr_out=0, mem_wdata_out=0, prescaler=0, step counter=0, step_pending=0.
REQ-033 During rst_in the previous-click register SHALL load click_in, so a button held through reset does not produce an edit.
REQ-034 Reset mid-edit aborts without a write; mem_we_out=0 in the cycle after rst_in is sampled high.

Verification (LOG_TICK_DIV=2, READ_LATENCY=2, LOG_MAX_SPEED=4, LOG_BOARD_SIZE=8)
REQ-035 Cursor (3,5), logic idle, click rises at cycle 0, mem_rdata_in=0 -> READ cycles 2-3, addr 0x0503; cycle 4 mem_we_out=1, wdata=1, addr 0x0503; edit_busy_out high cycles 1-4.
REQ-036 logic_busy_in=1 for cycles 0-9, click at cycle 0 -> WAIT until busy drops; no mem_we_out before cycle 13; exactly one write.
REQ-037 Second click edge during READ -> ignored; exactly one write pulse.
REQ-038 speed_in=15 -> step_out every 4 cycles; speed_in=14 -> every 8 cycles; speed_in=0 -> none over 200 cycles.
REQ-039 Step pending and click edge in the same idle cycle -> write completes first, step_out in the first cycle after return to IDLE, single pulse.
REQ-040 click_in held high through reset and after -> no edit; rst_in asserted during READ -> no write, outputs 0 next cycle.
